// File: rtl/ndp_drain_pkg.sv
// ndp_drain_pkg: shared definitions for the NDP result drain and related
// datapath blocks (beat selector, planned input feeder).
//   drain_state_e : drain controller state encoding
//   cnt_width()   : index width for a count of x items, never below 1 bit
package ndp_drain_pkg;

   typedef enum logic [0:0] {
      StIdle   = 1'b0,
      StStream = 1'b1
   } drain_state_e;

   // Width of an index over x items; a single item still gets a 1-bit index.
   function automatic int unsigned cnt_width(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/ndp_result_drain_if.sv
// ndp_result_drain_if: valid/ready beat stream from the result drain to the
// memory write path.
//   out_valid : beat available          (master -> slave)
//   out_ready : downstream accepts beat (slave -> master)
//   out_data  : beat payload, DATA_W bits
//   out_row   : row index of the current beat
//   out_beat  : beat index within the row
//   out_last  : final beat of the matrix
interface ndp_result_drain_if #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned ROW_W  = 2,
   parameter int unsigned BEAT_W = 4
);

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ROW_W-1:0]  out_row;
   logic [BEAT_W-1:0] out_beat;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_row,
      output out_beat,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_row,
      input  out_beat,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/ndp_beat_select.sv
// ndp_beat_select: combinational selection of one output beat from a flat,
// row-major matrix vector.
//   flat : ROWS x R elements of WIDTH bits, element (r,c) at (r*R+c)*WIDTH
//   row  : row index of the requested beat
//   beat : beat index within the row
//   data : BEAT_ELEMS elements, element e at [e*WIDTH +: WIDTH]
module ndp_beat_select
   import ndp_drain_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned R          = 256,
   parameter int unsigned ROWS       = 4,
   parameter int unsigned BEAT_ELEMS = 16,
   localparam int unsigned BPR    = R / BEAT_ELEMS,
   localparam int unsigned N      = R * ROWS,
   localparam int unsigned NBEATS = ROWS * BPR,
   localparam int unsigned ROW_W  = cnt_width(ROWS),
   localparam int unsigned BEAT_W = cnt_width(BPR),
   localparam int unsigned IDX_W  = cnt_width(NBEATS),
   localparam int unsigned BW     = BEAT_ELEMS * WIDTH
) (
   input  logic [N*WIDTH-1:0] flat,
   input  logic [ROW_W-1:0]   row,
   input  logic [BEAT_W-1:0]  beat,
   output logic [BW-1:0]      data
);

   logic [IDX_W-1:0] idx;

   // Rows are whole multiples of a beat, so beat k of the matrix (k = row*BPR
   // + beat) occupies the contiguous slice [k*BW +: BW]. The product wraps
   // modulo 2**IDX_W, which is harmless because row*BPR < NBEATS.
   assign idx = IDX_W'(row) * IDX_W'(BPR) + IDX_W'(beat);

   always_comb begin
      data = '0;
      for (int unsigned i = 0; i < NBEATS; i++) begin
         if (idx == IDX_W'(i)) begin
            data = flat[i*BW +: BW];
         end
      end
   end

endmodule

// File: rtl/ndp_result_drain.sv
// ndp_result_drain: streams the NDP systolic-array result matrix row-major as
// BEAT_ELEMS-element beats on a valid/ready interface.
//   clk, reset     : single clock, synchronous active-high reset
//   calc_done_flag : result-ready level from the NDP unit; its rising edge
//                    launches a drain
//   in_c           : flat result matrix, element (r,c) at (r*R+c)*WIDTH
//   out_if         : master side of the beat stream (ndp_result_drain_if)
//   busy           : drain in progress
//   drain_done     : one-cycle pulse after the final beat is accepted
//   overrun        : sticky, a done edge arrived while a drain was active
// Build option NDP_DRAIN_SNAPSHOT_EN: when defined, in_c is captured on the
// launching edge and beats come from that copy; otherwise in_c is indexed
// live and must be held stable by the NDP unit until drain_done.
module ndp_result_drain
   import ndp_drain_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ARR_WIDTH  = 4,
   parameter int unsigned ARR_HEIGHT = 4,
   parameter int unsigned SYS_WIDTH  = 64,
   parameter int unsigned SYS_HEIGHT = 1,
   parameter int unsigned BEAT_ELEMS = 16,
   localparam int unsigned R      = ARR_WIDTH * SYS_WIDTH,
   localparam int unsigned ROWS   = ARR_HEIGHT * SYS_HEIGHT,
   localparam int unsigned BPR    = R / BEAT_ELEMS,
   localparam int unsigned N      = R * ROWS,
   localparam int unsigned ROW_W  = cnt_width(ROWS),
   localparam int unsigned BEAT_W = cnt_width(BPR),
   localparam int unsigned BW     = BEAT_ELEMS * WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      calc_done_flag,
   input  logic [N*WIDTH-1:0]        in_c,
   ndp_result_drain_if.master        out_if,
   output logic                      busy,
   output logic                      drain_done,
   output logic                      overrun
);

   drain_state_e      state_q, state_d;
   logic              done_q;
   logic              start;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              drain_done_q, drain_done_d;
   logic              overrun_q, overrun_d;
   logic              handshake;
   logic              at_row_end;
   logic              at_last;
   logic [N*WIDTH-1:0] src;
   logic [BW-1:0]     beat_data;

   assign start      = calc_done_flag & ~done_q;
   // out_valid is exactly "in StStream", so the handshake never feeds back
   // into out_valid combinationally.
   assign handshake  = (state_q == StStream) && out_if.out_ready;
   assign at_row_end = (beat_q == BEAT_W'(BPR - 1));
   assign at_last    = at_row_end && (row_q == ROW_W'(ROWS - 1));

`ifdef NDP_DRAIN_SNAPSHOT_EN
   logic [N*WIDTH-1:0] snap_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
      end else if (start && (state_q == StIdle)) begin
         snap_q <= in_c;
      end
   end

   assign src = snap_q;
`else
   assign src = in_c;
`endif

   ndp_beat_select #(
      .WIDTH      (WIDTH),
      .R          (R),
      .ROWS       (ROWS),
      .BEAT_ELEMS (BEAT_ELEMS)
   ) u_beat_select (
      .flat (src),
      .row  (row_q),
      .beat (beat_q),
      .data (beat_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStream;
            end
         end
         StStream: begin
            if (handshake && at_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Position counters and status flags.
   always_comb begin
      row_d  = row_q;
      beat_d = beat_q;
      if ((state_q == StIdle) && start) begin
         row_d  = '0;
         beat_d = '0;
      end else if (handshake) begin
         if (at_last) begin
            // Park at (0,0) so the idle outputs read zero.
            row_d  = '0;
            beat_d = '0;
         end else if (at_row_end) begin
            row_d  = row_q + ROW_W'(1);
            beat_d = '0;
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end
      drain_done_d = handshake && at_last;
      // Any edge seen while streaming is dropped, including one that lands on
      // the final handshake.
      overrun_d    = overrun_q | (start && (state_q == StStream));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q       <= 1'b0;
         row_q        <= '0;
         beat_q       <= '0;
         drain_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         done_q       <= calc_done_flag;
         row_q        <= row_d;
         beat_q       <= beat_d;
         drain_done_q <= drain_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Output logic.
   always_comb begin
      out_if.out_valid = (state_q == StStream);
      out_if.out_row   = row_q;
      out_if.out_beat  = beat_q;
      out_if.out_last  = (state_q == StStream) && at_last;
      out_if.out_data  = (state_q == StStream) ? beat_data : '0;
      busy             = (state_q == StStream);
      drain_done       = drain_done_q;
      overrun          = overrun_q;
   end

endmodule

// File: tb/tb_ndp_result_drain.sv
// tb_ndp_result_drain: self-checking bench for ndp_result_drain using a
// 2x4-element matrix split into four 2-element beats. Directed table, hand
// sequences for the multi-cycle corners, then random traffic against a
// queue-based reference model.
module tb_ndp_result_drain;

   localparam int unsigned WIDTH      = 16;
   localparam int unsigned ARR_WIDTH  = 2;
   localparam int unsigned ARR_HEIGHT = 2;
   localparam int unsigned SYS_WIDTH  = 2;
   localparam int unsigned SYS_HEIGHT = 1;
   localparam int unsigned BEAT_ELEMS = 2;
   localparam int unsigned R          = 4;
   localparam int unsigned ROWS       = 2;
   localparam int unsigned BPR        = 2;
   localparam int unsigned NB         = 4;
   localparam int unsigned N          = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               calc_done_flag;
   logic [N*WIDTH-1:0] in_c;
   logic               busy;
   logic               drain_done;
   logic               overrun;

   ndp_result_drain_if #(.DATA_W(32), .ROW_W(1), .BEAT_W(1)) bus ();

   ndp_result_drain #(
      .WIDTH      (WIDTH),
      .ARR_WIDTH  (ARR_WIDTH),
      .ARR_HEIGHT (ARR_HEIGHT),
      .SYS_WIDTH  (SYS_WIDTH),
      .SYS_HEIGHT (SYS_HEIGHT),
      .BEAT_ELEMS (BEAT_ELEMS)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .calc_done_flag (calc_done_flag),
      .in_c           (in_c),
      .out_if         (bus),
      .busy           (busy),
      .drain_done     (drain_done),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit        rdy;
      bit        flag;
      bit        v;
      bit        l;
      bit        row;
      bit        beat;
      bit [31:0] d;
      bit        busy;
      bit        done;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rdy, input bit flag, input bit v, input bit l, input bit row,
                      input bit beat, input bit [31:0] d, input bit bsy, input bit done);
      vec_t x;
      x.rdy = rdy; x.flag = flag; x.v = v; x.l = l; x.row = row; x.beat = beat;
      x.d = d; x.busy = bsy; x.done = done;
      tbl.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*WIDTH-1:0] ref_matrix();
      logic [N*WIDTH-1:0] m;
      m = '0;
      for (int r = 0; r < int'(ROWS); r++)
         for (int c = 0; c < int'(R); c++)
            m[(r*R+c)*WIDTH +: WIDTH] = 16'(32'h0100 * r + c);
      return m;
   endfunction

   // Beat k of a drain: row k/BPR, elements (k%BPR)*BEAT_ELEMS onward.
   function automatic logic [31:0] beat_of(input logic [N*WIDTH-1:0] m, input int k);
      logic [31:0] d;
      int base;
      base = (k / int'(BPR)) * int'(R) + (k % int'(BPR)) * int'(BEAT_ELEMS);
      for (int e = 0; e < int'(BEAT_ELEMS); e++)
         d[e*WIDTH +: WIDTH] = m[(base+e)*WIDTH +: WIDTH];
      return d;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      calc_done_flag = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Bounded wait for drain_done, counting handshakes along the way.
   task automatic wait_done(input string tag, output int beats);
      bit seen;
      int n;
      seen = 0; n = 0; beats = 0;
      while (!seen && n < 20) begin
         if (bus.out_valid && bus.out_ready) beats++;
         tick();
         n++;
         if (drain_done) seen = 1;
      end
      chk({tag, ".done_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [N*WIDTH-1:0] refm;
      int hs;
      int nb;
      int pulses;

      refm = ref_matrix();
      in_c = refm;
      bus.out_ready = 1'b0;
      reset = 1'b1;
      calc_done_flag = 1'b0;
      tick();
      tick();
      chk("rst.valid", 32'(bus.out_valid), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(drain_done), 0);
      chk("rst.overrun", 32'(overrun), 0);
      chk("rst.row", 32'(bus.out_row), 0);
      chk("rst.beat", 32'(bus.out_beat), 0);
      chk("rst.last", 32'(bus.out_last), 0);
      chk("rst.data", bus.out_data, 0);
      reset = 1'b0;
      tick();

      // Full-rate drain, then the same drain with ready held low on beat 2.
      add(1, 1, 1, 0, 0, 0, 32'h0001_0000, 1, 0);
      add(1, 1, 1, 0, 0, 1, 32'h0003_0002, 1, 0);
      add(1, 0, 1, 0, 1, 0, 32'h0101_0100, 1, 0);
      add(1, 0, 1, 1, 1, 1, 32'h0103_0102, 1, 0);
      add(1, 0, 0, 0, 0, 0, 32'h0,         0, 1);
      add(1, 0, 0, 0, 0, 0, 32'h0,         0, 0);
      add(1, 1, 1, 0, 0, 0, 32'h0001_0000, 1, 0);
      add(1, 0, 1, 0, 0, 1, 32'h0003_0002, 1, 0);
      add(1, 0, 1, 0, 1, 0, 32'h0101_0100, 1, 0);
      add(0, 0, 1, 0, 1, 0, 32'h0101_0100, 1, 0);
      add(0, 0, 1, 0, 1, 0, 32'h0101_0100, 1, 0);
      add(0, 0, 1, 0, 1, 0, 32'h0101_0100, 1, 0);
      add(1, 0, 1, 1, 1, 1, 32'h0103_0102, 1, 0);
      add(1, 0, 0, 0, 0, 0, 32'h0,         0, 1);
      add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0);

      hs = 0;
      foreach (tbl[i]) begin
         bus.out_ready = tbl[i].rdy;
         calc_done_flag = tbl[i].flag;
         if (bus.out_valid && bus.out_ready) hs++;
         tick();
         chk($sformatf("tbl%0d.valid", i), 32'(bus.out_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d.last", i), 32'(bus.out_last), 32'(tbl[i].l));
         chk($sformatf("tbl%0d.row", i), 32'(bus.out_row), 32'(tbl[i].row));
         chk($sformatf("tbl%0d.beat", i), 32'(bus.out_beat), 32'(tbl[i].beat));
         chk($sformatf("tbl%0d.data", i), bus.out_data, tbl[i].d);
         chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d.done", i), 32'(drain_done), 32'(tbl[i].done));
         chk($sformatf("tbl%0d.overrun", i), 32'(overrun), 0);
      end
      chk("tbl.handshakes", 32'(hs), 32'd8);

      // Second edge during beat 1: drain continues, overrun sticks.
      bus.out_ready = 1'b1;
      calc_done_flag = 1'b1; tick();
      calc_done_flag = 1'b0; tick();
      chk("ovr.beat1", bus.out_data, 32'h0003_0002);
      calc_done_flag = 1'b1; tick();
      chk("ovr.set", 32'(overrun), 1);
      chk("ovr.cont_data", bus.out_data, 32'h0101_0100);
      calc_done_flag = 1'b0; tick();
      chk("ovr.last", 32'(bus.out_last), 1);
      tick();
      chk("ovr.done", 32'(drain_done), 1);
      chk("ovr.busy", 32'(busy), 0);
      calc_done_flag = 1'b1; tick();
      chk("ovr.redrain", 32'(bus.out_valid), 1);
      calc_done_flag = 1'b0;
      wait_done("ovr2", nb);
      chk("ovr2.beats", 32'(nb), 32'd4);
      chk("ovr.sticky", 32'(overrun), 1);
      do_reset();
      chk("ovr.cleared", 32'(overrun), 0);

      // Reset in the middle of a drain.
      calc_done_flag = 1'b1; tick();
      calc_done_flag = 1'b0; tick();
      tick();
      chk("mid.row_before", 32'(bus.out_row), 1);
      reset = 1'b1; tick();
      reset = 1'b0;
      chk("mid.valid", 32'(bus.out_valid), 0);
      chk("mid.busy", 32'(busy), 0);
      chk("mid.row", 32'(bus.out_row), 0);
      pulses = 0;
      if (drain_done) pulses++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (drain_done) pulses++;
      end
      chk("mid.no_done", 32'(pulses), 0);
      calc_done_flag = 1'b1; tick();
      calc_done_flag = 1'b0;
      chk("mid.restart_row", 32'(bus.out_row), 0);
      chk("mid.restart_beat", 32'(bus.out_beat), 0);
      chk("mid.restart_data", bus.out_data, 32'h0001_0000);
      wait_done("mid", nb);
      chk("mid.beats", 32'(nb), 32'd4);

      // Edge landing on the final handshake is dropped and flagged.
      tick();
      calc_done_flag = 1'b1; tick();
      calc_done_flag = 1'b0; tick(); tick(); tick();
      chk("coin.last", 32'(bus.out_last), 1);
      calc_done_flag = 1'b1; tick();
      chk("coin.done", 32'(drain_done), 1);
      chk("coin.valid", 32'(bus.out_valid), 0);
      chk("coin.overrun", 32'(overrun), 1);
      tick();
      chk("coin.idle", 32'(bus.out_valid), 0);
      do_reset();

      // Snapshot: payload survives in_c changing after the launch edge.
      calc_done_flag = 1'b1; tick();
      calc_done_flag = 1'b0;
`ifdef NDP_DRAIN_SNAPSHOT_EN
      in_c = '1;
`endif
      for (int k = 0; k < int'(NB); k++) begin
         chk($sformatf("snap.beat%0d", k), bus.out_data, beat_of(refm, k));
         tick();
      end
      chk("snap.done", 32'(drain_done), 1);
      in_c = refm;

      // Flag held high for 10 cycles gives exactly one drain.
      do_reset();
      pulses = 0; hs = 0;
      for (int i = 0; i < 20; i++) begin
         calc_done_flag = (i < 10);
         if (bus.out_valid && bus.out_ready) hs++;
         tick();
         if (drain_done) pulses++;
      end
      chk("hold.drains", 32'(pulses), 1);
      chk("hold.beats", 32'(hs), 4);
      chk("hold.overrun", 32'(overrun), 0);

      // Random traffic against a queue model of the drain.
      begin
         logic [N*WIDTH-1:0] m_mat;
         int m_q[$];
         bit m_done, m_over, m_prev;
         bit rst, rdy, flag, hsm, st, idle_before;
         do_reset();
         m_mat = '0; m_done = 0; m_over = 0; m_prev = 0;
         for (int cyc = 0; cyc < 400; cyc++) begin
            rst  = ($urandom_range(0, 49) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            flag = ($urandom_range(0, 3) == 0);
            if (m_q.size() == 0 && $urandom_range(0, 1) == 1)
               in_c = {$urandom, $urandom, $urandom, $urandom};
            if (rst) begin
               m_q.delete(); m_done = 0; m_over = 0; m_prev = 0;
            end else begin
               hsm = (m_q.size() > 0) && rdy;
               st = flag && !m_prev;
               idle_before = (m_q.size() == 0);
               m_done = 0;
               if (hsm) begin
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) m_done = 1;
               end
               if (st) begin
                  if (idle_before) begin
                     m_mat = in_c;
                     for (int k = 0; k < int'(NB); k++) m_q.push_back(k);
                  end else begin
                     m_over = 1;
                  end
               end
               m_prev = flag;
            end
            reset = rst; bus.out_ready = rdy; calc_done_flag = flag;
            tick();
            reset = 1'b0;
            chk($sformatf("rnd%0d.valid", cyc), 32'(bus.out_valid), 32'(m_q.size() > 0));
            chk($sformatf("rnd%0d.busy", cyc), 32'(busy), 32'(m_q.size() > 0));
            chk($sformatf("rnd%0d.done", cyc), 32'(drain_done), 32'(m_done));
            chk($sformatf("rnd%0d.overrun", cyc), 32'(overrun), 32'(m_over));
            if (m_q.size() > 0) begin
               chk($sformatf("rnd%0d.data", cyc), bus.out_data, beat_of(m_mat, m_q[0]));
               chk($sformatf("rnd%0d.row", cyc), 32'(bus.out_row), 32'(m_q[0] / int'(BPR)));
               chk($sformatf("rnd%0d.beat", cyc), 32'(bus.out_beat), 32'(m_q[0] % int'(BPR)));
               chk($sformatf("rnd%0d.last", cyc), 32'(bus.out_last),
                   32'(m_q[0] == int'(NB) - 1));
            end else begin
               chk($sformatf("rnd%0d.idle_data", cyc), bus.out_data, 0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
